// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Purpose  : Shared types and defaults for the serial sequence detector.
//            Holds the controller state enum, the default sizing of the
//            pattern and match counter, and a config legality helper.
// Ports    : none (package)
// Config   : SEQ_DET_OVERLAP_EN is consumed by seq_det_match, not here.
// Revision : 1.0  initial release
// ============================================================================
package seq_det_pkg;

  localparam int C_MAX_LEN_DEF = 8;   // default maximum pattern length
  localparam int C_CNT_W_DEF   = 8;   // default match counter width
  localparam int C_LEN_W       = 4;   // width of the cfg_len field

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A pattern length is usable when it selects at least one bit and fits
  // inside the history register.
  function automatic logic len_legal(input logic [C_LEN_W-1:0] len,
                                     input int                 max_len);
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_match.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_match
// Purpose  : History shift register, fill counter and pattern compare for
//            the serial sequence detector. hit is combinational and refers
//            to the history as it will look after the current sample shifts
//            in; the controller registers it.
// Ports    : clk      - clock, rising edge
//            reset    - synchronous active-high reset
//            clear    - synchronous clear of history and fill (run entry)
//            sample   - a qualified data bit is presented this cycle
//            din      - serial data bit
//            pattern  - stored pattern, bit 0 is the most recent bit
//            len      - stored pattern length (1..MAX_LEN)
//            hit      - this sample completes the pattern
// Config   : SEQ_DET_OVERLAP_EN defined   -> fill kept after a hit,
//                                            overlapping matches detected
//            SEQ_DET_OVERLAP_EN undefined -> fill cleared on a hit,
//                                            matches are non-overlapping
// Revision : 1.0  initial release
// ============================================================================
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = C_MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               sample,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [C_LEN_W-1:0] len,
  output logic               hit
);

  localparam int                  C_FILL_W   = $clog2(MAX_LEN + 1);
  localparam logic [C_FILL_W-1:0] C_FILL_MAX = C_FILL_W'(MAX_LEN);

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit C_OVERLAP = 1'b1;
`else
  localparam bit C_OVERLAP = 1'b0;
`endif

  logic [MAX_LEN-1:0]  r_hist;
  logic [C_FILL_W-1:0] r_fill;

  logic [MAX_LEN-1:0]  w_hist_next;
  logic [MAX_LEN-1:0]  w_mask;
  logic [C_FILL_W-1:0] w_fill_next;
  logic                w_eq;
  logic                w_full_enough;

  always_comb begin
    w_hist_next = (r_hist << 1) | MAX_LEN'(din);
    w_fill_next = (r_fill == C_FILL_MAX) ? r_fill : r_fill + C_FILL_W'(1);

    // Only the low len bits take part in the compare.
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(len));
    end

    w_eq          = ((w_hist_next ^ pattern) & w_mask) == '0;
    // Fill guards against matching on stale history left from before the
    // run started or from before the previous non-overlapping match.
    w_full_enough = 32'(w_fill_next) >= 32'(len);
    hit           = sample & w_eq & w_full_enough;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (sample) begin
      r_hist <= w_hist_next;
      if (hit && !C_OVERLAP) begin
        r_fill <= '0;
      end else begin
        r_fill <= w_fill_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Purpose  : Programmable serial sequence detector controller. Accepts a
//            pattern/length/threshold configuration, runs detection on a
//            qualified serial stream, counts matches and stops when the
//            count reaches a nonzero threshold.
// Ports    : clk         - clock, rising edge
//            reset       - synchronous active-high reset
//            cfg_valid   - configuration request
//            cfg_ready   - configuration accepted this cycle (IDLE/ARMED)
//            cfg_pattern - pattern, bit 0 is the most recent bit
//            cfg_len     - pattern length, legal 1..MAX_LEN
//            cfg_thresh  - match count ending the run, 0 = never
//            cfg_err     - one-cycle pulse, configuration rejected
//            start       - begin detection (honoured in ARMED only)
//            stop        - abort to IDLE from any state
//            din         - serial data bit
//            din_valid   - din qualifier
//            match       - one-cycle pulse per detected pattern
//            match_cnt   - matches counted in the current run
//            busy        - high in RUN
//            thresh_hit  - high in DONE
// Config   : SEQ_DET_OVERLAP_EN selects overlapping match detection
//            (see seq_det_match).
// Revision : 1.0  initial release
// ============================================================================
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = C_MAX_LEN_DEF,
  parameter int CNT_W   = C_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [C_LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               din,
  input  logic               din_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               thresh_hit
);

  state_t             r_state;
  state_t             w_state_next;

  logic [MAX_LEN-1:0] r_pattern;
  logic [C_LEN_W-1:0] r_len;
  logic [CNT_W-1:0]   r_thresh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_match;
  logic               r_cfg_err;

  logic               w_cfg_hs;
  logic               w_cfg_legal;
  logic               w_cfg_take;
  logic               w_run_entry;
  logic               w_sample;
  logic               w_hit;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_thresh_reached;

  assign cfg_ready  = (r_state == ST_IDLE) || (r_state == ST_ARMED);
  assign busy       = (r_state == ST_RUN);
  assign thresh_hit = (r_state == ST_DONE);
  assign match      = r_match;
  assign match_cnt  = r_cnt;
  assign cfg_err    = r_cfg_err;

  always_comb begin
    w_cfg_hs    = cfg_valid & cfg_ready;
    w_cfg_legal = len_legal(cfg_len, MAX_LEN);
    w_cfg_take  = w_cfg_hs & w_cfg_legal;
    // stop suppresses the sample so a completing bit cannot match or count.
    w_sample    = (r_state == ST_RUN) & din_valid & ~stop;
    w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    // DONE is taken on the same edge that registers the reaching match.
    w_thresh_reached = w_hit && (r_thresh != '0) && (w_cnt_inc == r_thresh);
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (stop) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_cfg_take)       w_state_next = ST_ARMED;
        ST_ARMED: if (start)            w_state_next = ST_RUN;
        ST_RUN:   if (w_thresh_reached) w_state_next = ST_DONE;
        ST_DONE:                        w_state_next = ST_DONE;
        default:                        w_state_next = ST_IDLE;
      endcase
    end
    w_run_entry = (r_state == ST_ARMED) && (w_state_next == ST_RUN);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stored configuration, match pulse, error pulse and match counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_thresh  <= '0;
      r_cnt     <= '0;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= w_hit;
      r_cfg_err <= w_cfg_hs & ~w_cfg_legal;

      if (w_cfg_take) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_thresh  <= cfg_thresh;
      end

      if (w_run_entry) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  seq_det_match #(
    .MAX_LEN (MAX_LEN)
  ) u_match (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_run_entry),
    .sample  (w_sample),
    .din     (din),
    .pattern (r_pattern),
    .len     (r_len),
    .hit     (w_hit)
  );

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_ctrl
// Purpose  : Self-checking bench for seq_det_ctrl. A queue-based reference
//            model predicts every output each cycle; directed scenarios
//            cover the documented use cases, followed by random traffic.
// Config   : follows SEQ_DET_OVERLAP_EN the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic [CNT_W-1:0]   cfg_thresh;
  logic               cfg_err;
  logic               start;
  logic               stop;
  logic               din;
  logic               din_valid;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               thresh_hit;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_mode;
  int m_pat;
  int m_len;
  int m_thr;
  int m_cnt;
  bit m_match;
  bit m_err;
  int m_bits[$];   // bits seen since the current match window began

  always #5 clk = ~clk;

  seq_det_ctrl #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_thresh  (cfg_thresh),
    .cfg_err     (cfg_err),
    .start       (start),
    .stop        (stop),
    .din         (din),
    .din_valid   (din_valid),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .thresh_hit  (thresh_hit)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit hs;
    bit legal;
    bit matched;
    if (reset) begin
      m_mode  = M_IDLE;
      m_pat   = 0;
      m_len   = 0;
      m_thr   = 0;
      m_cnt   = 0;
      m_match = 1'b0;
      m_err   = 1'b0;
      m_bits.delete();
      return;
    end
    hs      = cfg_valid && (m_mode == M_IDLE || m_mode == M_ARMED);
    legal   = (int'(cfg_len) >= 1) && (int'(cfg_len) <= MAX_LEN);
    m_err   = hs && !legal;
    m_match = 1'b0;
    if (stop) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:  if (hs && legal) m_mode = M_ARMED;
        M_ARMED: if (start) begin
                   m_mode = M_RUN;
                   m_cnt  = 0;
                   m_bits.delete();
                 end
        M_RUN: if (din_valid) begin
                 m_bits.push_back(int'(din));
                 if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                 matched = 1'b0;
                 if (m_bits.size() >= m_len) begin
                   matched = 1'b1;
                   for (int k = 0; k < m_len; k++) begin
                     if (m_bits[m_bits.size() - 1 - k] != ((m_pat >> k) & 1))
                       matched = 1'b0;
                   end
                 end
                 if (matched) begin
                   m_match = 1'b1;
                   if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                   if (!OVL) m_bits.delete();
                   if (m_thr != 0 && m_cnt == m_thr) m_mode = M_DONE;
                 end
               end
        default: ;
      endcase
    end
    if (hs && legal) begin
      m_pat = int'(cfg_pattern);
      m_len = int'(cfg_len);
      m_thr = int'(cfg_thresh);
    end
  endtask

  // One clock: predict, let the edge happen, compare away from the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("cyc_match",      32'(match),      32'(m_match));
    check("cyc_match_cnt",  32'(match_cnt),  32'(m_cnt));
    check("cyc_busy",       32'(busy),       32'(m_mode == M_RUN));
    check("cyc_thresh_hit", 32'(thresh_hit), 32'(m_mode == M_DONE));
    check("cyc_cfg_ready",  32'(cfg_ready),
          32'(m_mode == M_IDLE || m_mode == M_ARMED));
    check("cyc_cfg_err",    32'(cfg_err),    32'(m_err));
  endtask

  task automatic idle_inputs();
    reset     = 1'b0;
    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                        input logic [7:0] thr);
    idle_inputs();
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_thresh  = thr;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    idle_inputs();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_stop();
    idle_inputs();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  // Sends bits[n-1] first, bits[0] last.
  task automatic send_bits(input int n, input logic [31:0] bits);
    for (int i = n - 1; i >= 0; i--) begin
      idle_inputs();
      din_valid = 1'b1;
      din       = bits[i];
      cycle();
    end
    din_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_thresh  = '0;

    // Reset state
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);

    // Single match one cycle after the 4th bit
    do_cfg(8'h09, 4'd4, 8'd0);
    do_start();
    check("run_busy", 32'(busy), 32'd1);
    send_bits(4, 32'b1001);
    check("single_match", 32'(match),     32'd1);
    check("single_cnt",   32'(match_cnt), 32'd1);
    idle_inputs();
    cycle();
    check("single_pulse_end", 32'(match), 32'd0);

    // Overlap behaviour on 1001001
    do_stop();
    do_cfg(8'h09, 4'd4, 8'd0);
    do_start();
    send_bits(7, 32'b1001001);
    check("overlap_cnt", 32'(match_cnt), OVL ? 32'd2 : 32'd1);

    // Threshold of 3
    do_stop();
    do_cfg(8'h09, 4'd4, 8'd3);
    do_start();
    send_bits(12, 32'b100110011001);
    check("thr_hit",   32'(thresh_hit), 32'd1);
    check("thr_busy",  32'(busy),       32'd0);
    check("thr_match", 32'(match),      32'd1);
    check("thr_cnt",   32'(match_cnt),  32'd3);
    send_bits(4, 32'b1001);
    check("thr_cnt_hold", 32'(match_cnt), 32'd3);
    check("thr_no_match", 32'(match),     32'd0);

    // Illegal lengths
    do_stop();
    do_cfg(8'h09, 4'd0, 8'd0);
    check("len0_err",   32'(cfg_err),   32'd1);
    check("len0_ready", 32'(cfg_ready), 32'd1);
    do_start();
    check("len0_err_pulse", 32'(cfg_err), 32'd0);
    check("len0_no_start",  32'(busy),    32'd0);
    do_cfg(8'h09, 4'd9, 8'd0);
    check("len9_err", 32'(cfg_err), 32'd1);
    do_start();
    check("len9_no_start", 32'(busy), 32'd0);

    // stop together with the completing bit
    do_cfg(8'h09, 4'd4, 8'd0);
    do_start();
    send_bits(3, 32'b100);
    idle_inputs();
    din_valid = 1'b1;
    din       = 1'b1;
    stop      = 1'b1;
    cycle();
    check("stop_no_match", 32'(match),     32'd0);
    check("stop_no_cnt",   32'(match_cnt), 32'd0);
    check("stop_idle",     32'(busy),      32'd0);

    // Reset mid-run
    do_cfg(8'h09, 4'd4, 8'd0);
    do_start();
    send_bits(4, 32'b1001);
    send_bits(2, 32'b10);
    idle_inputs();
    reset     = 1'b1;
    din_valid = 1'b1;
    cycle();
    check("mrst_cnt",   32'(match_cnt),  32'd0);
    check("mrst_busy",  32'(busy),       32'd0);
    check("mrst_ready", 32'(cfg_ready),  32'd1);
    check("mrst_match", 32'(match),      32'd0);
    check("mrst_hit",   32'(thresh_hit), 32'd0);
    do_start();
    check("mrst_no_start", 32'(busy), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      cfg_valid   = ($urandom_range(0, 11) == 0);
      cfg_len     = 4'($urandom_range(0, 10));
      cfg_pattern = 8'($urandom);
      cfg_thresh  = 8'($urandom_range(0, 4));
      start       = ($urandom_range(0, 5) == 0);
      din_valid   = ($urandom_range(0, 3) != 0);
      din         = 1'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum programmable pattern length in bits.
REQ-002 Parameter CNT_W, default 8, width of the match counter and threshold.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_valid  input  1  configuration request.
REQ-006 cfg_ready  output  1  controller accepts configuration this cycle.
REQ-007 cfg_pattern  input  MAX_LEN  pattern; bit 0 is the last (most recent) bit of the sequence.
REQ-008 cfg_len  input  4  pattern length, legal range 1..MAX_LEN.
REQ-009 cfg_thresh  input  CNT_W  match count that ends the run; 0 means never.
REQ-010 cfg_err  output  1  one-cycle pulse: a configuration was rejected.
REQ-011 start  input  1  begin detection.
REQ-012 stop  input  1  abort and return to idle.
REQ-013 din  input  1  serial data bit.
REQ-014 din_valid  input  1  din qualifier.
REQ-015 match  output  1  one-cycle pulse per detected pattern.
REQ-016 match_cnt  output  CNT_W  matches counted in the current run.
REQ-017 busy  output  1  high in RUN.
REQ-018 thresh_hit  output  1  high in DONE.

Function
REQ-019 FSM states IDLE, ARMED, RUN, DONE. IDLE -> ARMED on accepted legal config. ARMED -> RUN on start. RUN -> DONE when match_cnt reaches a nonzero cfg_thresh. stop -> IDLE from any state.
REQ-020 cfg_ready = 1 in IDLE and ARMED; 0 in RUN and DONE.
REQ-021 A handshake (cfg_valid & cfg_ready) with cfg_len 0 or > MAX_LEN pulses cfg_err the next cycle, leaves state and stored config unchanged.
REQ-022 A legal handshake in ARMED replaces the stored config and stays ARMED.
REQ-023 start is ignored in IDLE, RUN and DONE.
REQ-024 On RUN entry: history shift register, fill count and match_cnt cleared.
REQ-025 In RUN, each din_valid cycle shifts din into history bit 0; the fill count increments, saturating at MAX_LEN.
REQ-026 Match condition: fill count >= len and the low len history bits (after the shift) equal the low len pattern bits.
REQ-027 match is registered: it asserts the cycle after the din_valid sample that completes the pattern.
REQ-028 match_cnt increments with each match and saturates at all-ones.
REQ-029 DONE is entered in the same edge as the threshold-reaching match.
REQ-030 din_valid is ignored outside RUN.
REQ-031 stop and a completing sample in the same cycle: stop wins, with no match and no count.
REQ-032 match_cnt holds its value in DONE and ARMED and clears only on RUN entry or reset.

Reset
REQ-033 reset forces IDLE and clears history, fill count, stored config, match_cnt, match, cfg_err, busy and thresh_hit; cfg_ready = 1.
REQ-034 reset asserted mid-run discards all progress, and the next cycle behaves as post-reset IDLE.

Configuration
REQ-035 Macro SEQ_DET_OVERLAP_EN defined: history and fill count are retained after a match, so overlapping matches are detected.
REQ-036 Macro undefined: fill count is cleared on each match, so matches are non-overlapping.

Structure
REQ-037 Package seq_det_pkg holds the state enum typedef and the MAX_LEN and CNT_W defaults.
REQ-038 Sub-module seq_det_match holds the history shift register, fill count and compare; the controller FSM lives in seq_det_ctrl.

Verification
REQ-039 Reset, then cfg pattern=4'b1001, len=4, thresh=0, start, stream 1,0,0,1 -> one match pulse one cycle after the 4th bit; match_cnt=1.
REQ-040 Same config, stream 1001001 -> match_cnt=2 with SEQ_DET_OVERLAP_EN, match_cnt=1 without.
REQ-041 thresh=3, stream 1001 repeated 3x -> thresh_hit=1 and busy=0 on the third match; further data leaves match_cnt=3.
REQ-042 cfg_len=0 or cfg_len=9 -> cfg_err pulse, state stays IDLE, and start is ignored.
REQ-043 stop coincident with the completing bit -> no match, state IDLE; reset mid-RUN -> all outputs at reset values the next cycle.
